// File: rtl/scd_pkg.sv
// Shared types and defaults for the serial check-word decoder.
// Frame layout: 12 data bits MSB first, then 4 check bits MSB first.
package scd_pkg;

    localparam int SCD_DATA_W  = 12;
    localparam int SCD_CHK_W   = 4;
    localparam int SCD_FRAME_W = SCD_DATA_W + SCD_CHK_W;

    // Mask k occupies bits [k*DATA_W +: DATA_W]
    localparam logic [SCD_DATA_W*SCD_CHK_W-1:0] SCD_CHK_MASK =
        48'h0F3_5A6_C39_9E1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } scd_state_t;

endpackage

// File: rtl/scd_syndrome.sv
// Combinational syndrome: received check bits XOR recomputed parity.
// Uses the same mask table as the transmit-side generator.
import scd_pkg::*;

module scd_syndrome #(
    parameter int DATA_W = SCD_DATA_W,
    parameter int CHK_W  = SCD_CHK_W,
    parameter logic [DATA_W*CHK_W-1:0] CHK_MASK = SCD_CHK_MASK
) (
    input  logic [DATA_W-1:0] data,
    input  logic [CHK_W-1:0]  chk,
    output logic [CHK_W-1:0]  syn
);

    // Each syndrome bit compares one received check bit to its mask parity
    always_comb begin
        syn = '0;
        for (int k = 0; k < CHK_W; k++) begin
            syn[k] = chk[k] ^ (^(data & CHK_MASK[k*DATA_W +: DATA_W]));
        end
    end

endmodule

// File: rtl/serial_check_decoder.sv
// Serial receive decoder: deserialises a data+check frame and
// reports data, syndrome and error through a one-entry buffer.
import scd_pkg::*;

module serial_check_decoder #(
    parameter int DATA_W   = SCD_DATA_W,
    parameter int CHK_W    = SCD_CHK_W,
    parameter logic [DATA_W*CHK_W-1:0] CHK_MASK = SCD_CHK_MASK,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sin_bit,
    input  logic                sin_valid,
    input  logic                sin_sof,
    output logic                sin_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [CHK_W-1:0]    out_syn,
    output logic                out_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                frame_abort,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int F     = DATA_W + CHK_W;
    localparam int CNT_W = $clog2(F + 1);

    scd_state_t        state;
    logic [F-1:0]      sr;
    logic [CNT_W-1:0]  count;

    logic              accept;
    logic              drain;
    logic [F-1:0]      frame_w;
    logic [DATA_W-1:0] frame_data;
    logic [CHK_W-1:0]  frame_chk;
    logic [CHK_W-1:0]  frame_syn;

    assign sin_ready = (state != HOLD);
    assign accept    = sin_valid && sin_ready;
    assign drain     = out_valid && out_ready;

    // In HOLD the frame is parked in sr; otherwise the incoming bit
    // completes it, so the syndrome is ready in the same cycle.
    assign frame_w    = (state == HOLD) ? sr : {sr[F-2:0], sin_bit};
    assign frame_data = frame_w[F-1 -: DATA_W];
    assign frame_chk  = frame_w[CHK_W-1:0];

    scd_syndrome #(
        .DATA_W   (DATA_W),
        .CHK_W    (CHK_W),
        .CHK_MASK (CHK_MASK)
    ) u_syn (
        .data (frame_data),
        .chk  (frame_chk),
        .syn  (frame_syn)
    );

    // Receive FSM, output buffer and error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sr          <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_syn     <= '0;
            out_err     <= 1'b0;
            frame_abort <= 1'b0;
            err_count   <= '0;
        end else begin
            frame_abort <= 1'b0;

            if (drain) begin
                out_valid <= 1'b0;
                if (out_err && (err_count != '1)) begin
                    err_count <= err_count + ERRCNT_W'(1);
                end
            end

            unique case (state)
                IDLE: begin
                    if (accept && sin_sof) begin
                        sr    <= {{(F-1){1'b0}}, sin_bit};
                        count <= CNT_W'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        if (sin_sof) begin
                            sr          <= {{(F-1){1'b0}}, sin_bit};
                            count       <= CNT_W'(1);
                            frame_abort <= 1'b1;
                        end else if (count == CNT_W'(F - 1)) begin
                            count <= '0;
                            if (!out_valid || drain) begin
                                out_valid <= 1'b1;
                                out_data  <= frame_data;
                                out_syn   <= frame_syn;
                                out_err   <= |frame_syn;
                                state     <= IDLE;
                            end else begin
                                sr    <= frame_w;
                                state <= HOLD;
                            end
                        end else begin
                            sr    <= {sr[F-2:0], sin_bit};
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (drain) begin
                        out_valid <= 1'b1;
                        out_data  <= frame_data;
                        out_syn   <= frame_syn;
                        out_err   <= |frame_syn;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_check_decoder.sv
// Directed bench for serial_check_decoder with immediate assertions.
// Expected frames: 12'hA5C has check 4'h6; flipping data bit 0 gives syndrome 4'b1011.
module tb_serial_check_decoder;

    logic        clk;
    logic        rst_n;
    logic        sin_bit;
    logic        sin_valid;
    logic        sin_sof;
    logic        sin_ready;
    logic [11:0] out_data;
    logic [3:0]  out_syn;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic        frame_abort;
    logic [7:0]  err_count;

    int vectors    = 0;
    int miscompares = 0;
    int xfer_cnt   = 0;
    int abort_cnt  = 0;
    int base_x;
    int base_a;
    logic [11:0] last_data;

    localparam logic [15:0] CLEAN = 16'hA5C6;
    localparam logic [15:0] BAD   = 16'hA5D6;

    serial_check_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin_bit     (sin_bit),
        .sin_valid   (sin_valid),
        .sin_sof     (sin_sof),
        .sin_ready   (sin_ready),
        .out_data    (out_data),
        .out_syn     (out_syn),
        .out_err     (out_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_abort (frame_abort),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count transfers and abort pulses as seen just before each edge
    always @(posedge clk) begin
        if (out_valid && out_ready) begin
            xfer_cnt++;
            last_data = out_data;
        end
        if (frame_abort) abort_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        sin_valid = 1'b1;
        sin_bit   = b;
        sin_sof   = s;
        step();
    endtask

    task automatic send_frame(input logic [15:0] f);
        for (int i = 15; i >= 0; i--) send_bit(f[i], i == 15);
        sin_valid = 1'b0;
        sin_sof   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        sin_bit   = 1'b0;
        sin_valid = 1'b0;
        sin_sof   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_syn", 32'(out_syn), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_abort", 32'(frame_abort), 32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);
        check("rst_ready", 32'(sin_ready), 32'd1);

        // Clean frame, latency one cycle after last bit
        send_frame(CLEAN);
        check("clean_valid", 32'(out_valid), 32'd1);
        check("clean_data", 32'(out_data), 32'hA5C);
        check("clean_syn", 32'(out_syn), 32'h0);
        check("clean_err", 32'(out_err), 32'd0);
        step();
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'hA5C);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("clean_drain", 32'(out_valid), 32'd0);
        check("clean_errcnt", 32'(err_count), 32'd0);

        // Data bit 0 flipped
        send_frame(BAD);
        check("bad_data", 32'(out_data), 32'hA5D);
        check("bad_syn", 32'(out_syn), 32'hB);
        check("bad_err", 32'(out_err), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bad_errcnt", 32'(err_count), 32'd1);
        check("bad_drain", 32'(out_valid), 32'd0);

        // Backpressure: second frame parks in HOLD
        send_frame(CLEAN);
        send_frame(BAD);
        check("bp_ready", 32'(sin_ready), 32'd0);
        check("bp_first", 32'(out_data), 32'hA5C);
        check("bp_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_reload_v", 32'(out_valid), 32'd1);
        check("bp_second", 32'(out_data), 32'hA5D);
        check("bp_second_syn", 32'(out_syn), 32'hB);
        check("bp_ready_back", 32'(sin_ready), 32'd1);
        check("bp_errcnt1", 32'(err_count), 32'd1);
        step();
        check("bp_empty", 32'(out_valid), 32'd0);
        check("bp_errcnt2", 32'(err_count), 32'd2);

        // Back-to-back frames with out_ready held high
        base_x = xfer_cnt;
        send_frame(16'h0000);
        send_frame(CLEAN);
        step();
        check("tp_xfers", 32'(xfer_cnt - base_x), 32'd2);
        check("tp_last", 32'(last_data), 32'hA5C);
        check("tp_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Early sof at bit 7
        base_x = xfer_cnt;
        base_a = abort_cnt;
        for (int i = 15; i >= 9; i--) send_bit(BAD[i], i == 15);
        send_bit(CLEAN[15], 1'b1);
        check("abort_pulse", 32'(frame_abort), 32'd1);
        for (int i = 14; i >= 0; i--) send_bit(CLEAN[i], 1'b0);
        sin_valid = 1'b0;
        check("abort_clear", 32'(frame_abort), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd1);
        check("abort_data", 32'(out_data), 32'hA5C);
        check("abort_syn", 32'(out_syn), 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("abort_once", 32'(abort_cnt - base_a), 32'd1);
        check("abort_xfers", 32'(xfer_cnt - base_x), 32'd1);

        // Error counter saturation
        out_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            send_frame(BAD);
            if (n == 99) check("sat_mid", 32'(err_count), 32'd101);
        end
        check("sat_255", 32'(err_count), 32'd255);
        step();
        check("sat_stay", 32'(err_count), 32'd255);
        out_ready = 1'b0;

        // Asynchronous reset mid-frame
        send_frame(CLEAN);
        for (int i = 15; i >= 7; i--) send_bit(CLEAN[i], i == 15);
        sin_valid = 1'b0;
        sin_sof   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_errcnt", 32'(err_count), 32'd0);
        check("arst_ready", 32'(sin_ready), 32'd1);
        check("arst_abort", 32'(frame_abort), 32'd0);
        rst_n = 1'b1;
        base_a = abort_cnt;
        send_frame(CLEAN);
        check("post_valid", 32'(out_valid), 32'd1);
        check("post_data", 32'(out_data), 32'hA5C);
        check("post_syn", 32'(out_syn), 32'h0);
        step();
        check("post_noabort", 32'(abort_cnt - base_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
